// File: rtl/risc_v_pkg.sv
// Shared constants for the RV32I OP / OP-IMM encoder.
//   - Opcodes, funct3/funct7 values, and the alu_op codes used by the
//     control unit.
//   - Encoder FSM state type and the encoder result struct.
package risc_v_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // alu_op codes, identical to the control-unit decode output
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_SUB  = 5'd16;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

endpackage

// File: rtl/risc_v_instr_fifo.sv
// Synchronous show-ahead FIFO, DEPTH x W.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write port (ignored when full)
//   pop           : read acknowledge (ignored when empty)
//   rdata         : current head; 0 when empty
//   full, empty   : occupancy flags
module risc_v_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/risc_v_instr_encoder.sv
// Packs {alu_op, is_I_type, rd, rs1, rs2, imm} into RV32I OP / OP-IMM words,
// queues them and writes them to instruction memory at consecutive byte
// addresses.
//   clk, rst                : clock, synchronous active-high reset
//   start, flush, load_base : IDLE->RUN, RUN->DRAIN, load pointer (IDLE only)
//   base_addr               : byte address loaded by load_base
//   in_valid/in_ready       : request handshake, fields alu_op..imm
//   imem_valid/imem_ready   : write handshake, imem_addr / imem_wdata
//   busy, done              : state!=IDLE, one-cycle pulse in DONE
//   err_illegal             : sticky illegal-request flag, cleared by start
//   words_written           : completed imem writes since start (wraps)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
module risc_v_instr_encoder
    import risc_v_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   flush,
    input  logic                   load_base,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             alu_op,
    input  logic                   is_I_type,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [11:0]            imm,
    output logic                   imem_valid,
    input  logic                   imem_ready,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [WORD_LENGTH-1:0] imem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err_illegal,
    output logic [CNT_W-1:0]       words_written
);

    function automatic enc_t encode(
        input logic [4:0]  op,
        input logic        is_i,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_rs1,
        input logic [4:0]  f_rs2,
        input logic [11:0] f_imm
    );
        enc_t        res;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        shift;
        logic [11:0] imm_eff;
        f3        = F3_ADD_SUB;
        f7        = F7_BASE;
        res.legal = 1'b1;
        shift     = 1'b0;
        case (op)
            ALU_ADD:  f3 = F3_ADD_SUB;
            ALU_SUB:  begin f7 = F7_ALT; res.legal = !is_i; end
            ALU_SLL:  begin f3 = F3_SLL; shift = 1'b1; end
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            ALU_XOR:  f3 = F3_XOR;
            ALU_SRL:  begin f3 = F3_SR; shift = 1'b1; end
            ALU_SRA:  begin f3 = F3_SR; f7 = F7_ALT; shift = 1'b1; end
            ALU_OR:   f3 = F3_OR;
            ALU_AND:  f3 = F3_AND;
            default:  res.legal = 1'b0;
        endcase
        // Immediate shifts carry funct7 in imm[11:5]; the caller's upper bits are discarded.
        imm_eff  = shift ? {f7, f_imm[4:0]} : f_imm;
        res.word = is_i ? {imm_eff, f_rs1, f3, f_rd, OPC_OP_IMM}
                        : {f7, f_rs2, f_rs1, f3, f_rd, OPC_OP};
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    enc_t enc;
    logic accept, push, handshake;
    logic fifo_full, fifo_empty;

    assign enc       = encode(alu_op, is_I_type, rd, rs1, rs2, imm);
    assign in_ready  = (state_q == ST_RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    // Illegal requests are consumed but never reach the FIFO.
    assign push      = accept && enc.legal;
    assign handshake = imem_valid && imem_ready;

    risc_v_instr_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_LENGTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc.word),
        .pop   (handshake),
        .rdata (imem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_valid    = !fifo_empty;
    assign imem_addr     = addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err_illegal   = err_q;
    assign words_written = cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (handshake) begin
            addr_d = addr_q + ADDR_W'(4);
            cnt_d  = cnt_q + CNT_W'(1);
        end
        if (accept && !enc.legal) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (load_base) begin
                    addr_d = base_addr;
                end
                if (start) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_risc_v_instr_encoder.sv
module tb_risc_v_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start = 0, flush = 0, load_base = 0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [4:0]        alu_op = 0, rd = 0, rs1 = 0, rs2 = 0;
    logic              is_I_type = 0;
    logic [11:0]       imm = 0;
    logic              imem_valid;
    logic              imem_ready = 0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err_illegal;
    logic [CNT_W-1:0]  words_written;

    risc_v_instr_encoder #(
        .WORD_LENGTH (32),
        .ADDR_W      (ADDR_W),
        .DEPTH       (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .flush         (flush),
        .load_base     (load_base),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op        (alu_op),
        .is_I_type     (is_I_type),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .imem_valid    (imem_valid),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .busy          (busy),
        .done          (done),
        .err_illegal   (err_illegal),
        .words_written (words_written)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr = '0;
    logic        rand_ready = 0;
    logic [63:0] mon_exp;

    // Reference encoding straight from the instruction-set table: {legal, word}.
    function automatic logic [32:0] model(input logic [4:0] op, input logic is_i,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [11:0] im);
        logic [2:0] f3 = 3'b000;
        logic [6:0] f7 = 7'h00;
        logic       ok = 1'b1;
        logic       shamt_form = 1'b0;
        logic [11:0] imx;
        case (op)
            5'd0:  f3 = 3'b000;
            5'd1:  begin f3 = 3'b001; shamt_form = 1'b1; end
            5'd2:  f3 = 3'b010;
            5'd3:  f3 = 3'b011;
            5'd4:  f3 = 3'b100;
            5'd5:  begin f3 = 3'b101; shamt_form = 1'b1; end
            5'd6:  begin f3 = 3'b101; f7 = 7'h20; shamt_form = 1'b1; end
            5'd7:  f3 = 3'b111;
            5'd8:  f3 = 3'b110;
            5'd16: begin f3 = 3'b000; f7 = 7'h20; ok = !is_i; end
            default: ok = 1'b0;
        endcase
        imx = shamt_form ? {f7, im[4:0]} : im;
        if (is_i) return {ok, imx, s1, f3, d, 7'h13};
        return {ok, f7, s2, s1, f3, d, 7'h33};
    endfunction

    // Write monitor: every imem handshake pops one expected {addr, data}.
    always @(negedge clk) begin
        if (!rst && imem_valid && imem_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL imem_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_exp) begin
                    n_err++;
                    $display("FAIL imem_write: got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr, imem_wdata, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    // Random write back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [31:0] base);
        @(posedge clk); #1;
        start = 1; load_base = 1; base_addr = base; exp_addr = base;
        @(posedge clk); #1;
        start = 0; load_base = 0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
    endtask

    task automatic drive_req(input logic [4:0] op, input logic is_i, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                             input logic [32:0] expv);
        @(posedge clk); #1;
        in_valid = 1; alu_op = op; is_I_type = is_i; rd = d; rs1 = s1; rs2 = s2; imm = im;
        if (expv[32]) begin
            exp_q.push_back({exp_addr, expv[31:0]});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic wait_accept(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        n_vec++;
        if (k == 300) begin
            n_err++;
            $display("FAIL %s_accept: in_ready never rose, expected acceptance", name);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send(input logic [4:0] op, input logic is_i, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                        input logic [32:0] expv, input string name);
        drive_req(op, is_i, d, s1, s2, im, expv);
        wait_accept(name);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        n_vec++;
        if (k == 300) begin
            n_err++;
            $display("FAIL %s_idle: busy stuck at 1, expected 0", name);
        end
    endtask

    task automatic check_empty_q(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d writes missing, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({imem_valid, in_ready, busy, done, err_illegal} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got v/r/b/d/e=%b, expected 00000",
                     {imem_valid, in_ready, busy, done, err_illegal});
        end
        n_vec++;
        if (words_written !== '0) begin
            n_err++; $display("FAIL reset_count: got %0d, expected 0", words_written);
        end
        n_vec++;
        if (imem_addr !== '0) begin
            n_err++; $display("FAIL reset_addr: got %h, expected 0", imem_addr);
        end
        n_vec++;
        if (imem_wdata !== '0) begin
            n_err++; $display("FAIL reset_wdata: got %h, expected 0", imem_wdata);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_sub();
        imem_ready = 1;
        do_start(32'h100);
        send(5'd16, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, {1'b1, 32'h402081B3}, "sub");
        do_flush();
        wait_idle("sub");
        n_vec++;
        if (words_written !== 16'd1) begin
            n_err++; $display("FAIL sub_count: got %0d, expected 1", words_written);
        end
        n_vec++;
        if (imem_addr !== 32'h104) begin
            n_err++; $display("FAIL sub_addr_next: got %h, expected 00000104", imem_addr);
        end
        check_empty_q("sub");
    endtask

    task automatic test_srai();
        imem_ready = 1;
        do_start(32'h180);
        send(5'd6, 1'b1, 5'd5, 5'd6, 5'd0, 12'h003, {1'b1, 32'h40335293}, "srai");
        send(5'd6, 1'b1, 5'd5, 5'd6, 5'd9, 12'hFE3, {1'b1, 32'h40335293}, "srai_hi");
        do_flush();
        wait_idle("srai");
        n_vec++;
        if (words_written !== 16'd2) begin
            n_err++; $display("FAIL srai_count: got %0d, expected 2", words_written);
        end
        check_empty_q("srai");
    endtask

    task automatic test_illegal();
        int seen_valid = 0;
        imem_ready = 1;
        do_start(32'h200);
        send(5'd16, 1'b1, 5'd1, 5'd2, 5'd3, 12'h7, {1'b0, 32'h0}, "ill_subi");
        send(5'd9, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0, {1'b0, 32'h0}, "ill_op9");
        repeat (3) begin
            @(negedge clk);
            if (imem_valid) seen_valid++;
        end
        n_vec++;
        if (seen_valid != 0) begin
            n_err++; $display("FAIL ill_valid: imem_valid high %0d cycles, expected 0", seen_valid);
        end
        n_vec++;
        if (err_illegal !== 1'b1) begin
            n_err++; $display("FAIL ill_err: got %b, expected 1", err_illegal);
        end
        n_vec++;
        if (words_written !== 16'd0) begin
            n_err++; $display("FAIL ill_count: got %0d, expected 0", words_written);
        end
        do_flush();
        wait_idle("ill");
        n_vec++;
        if (err_illegal !== 1'b1) begin
            n_err++; $display("FAIL ill_sticky: got %b, expected 1", err_illegal);
        end
    endtask

    task automatic test_backpressure();
        int ready_seen = 0;
        imem_ready = 0;
        do_start(32'h400);
        @(negedge clk);
        n_vec++;
        if (err_illegal !== 1'b0) begin
            n_err++; $display("FAIL bp_err_clear: got %b, expected 0", err_illegal);
        end
        for (int i = 0; i < 4; i++) begin
            send(5'd0, 1'b1, 5'(i + 1), 5'd0, 5'd0, 12'(i),
                 model(5'd0, 1'b1, 5'(i + 1), 5'd0, 5'd0, 12'(i)), "bp");
        end
        drive_req(5'd4, 1'b0, 5'd7, 5'd8, 5'd9, 12'h0, model(5'd4, 1'b0, 5'd7, 5'd8, 5'd9, 12'h0));
        repeat (3) begin
            @(negedge clk);
            if (in_ready) ready_seen++;
        end
        n_vec++;
        if (ready_seen != 0) begin
            n_err++; $display("FAIL bp_full: in_ready high %0d cycles while full, expected 0", ready_seen);
        end
        n_vec++;
        if (imem_addr !== 32'h400) begin
            n_err++; $display("FAIL bp_hold_addr: got %h, expected 00000400", imem_addr);
        end
        @(posedge clk); #1;
        imem_ready = 1;
        wait_accept("bp5");
        do_flush();
        wait_idle("bp");
        n_vec++;
        if (words_written !== 16'd5) begin
            n_err++; $display("FAIL bp_count: got %0d, expected 5", words_written);
        end
        check_empty_q("bp");
    endtask

    task automatic test_flush_done();
        int empty_c = -1, done_c = -1, busy_c = -1, done_n = 0;
        imem_ready = 0;
        do_start(32'h500);
        send(5'd7, 1'b0, 5'd10, 5'd11, 5'd12, 12'h0, model(5'd7, 1'b0, 5'd10, 5'd11, 5'd12, 12'h0), "fd1");
        // Second request accepted in the same cycle as flush must still be written.
        drive_req(5'd1, 1'b1, 5'd13, 5'd14, 5'd0, 12'hFFF, model(5'd1, 1'b1, 5'd13, 5'd14, 5'd0, 12'hFFF));
        flush = 1;
        wait_accept("fd2");
        flush = 0;
        imem_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!imem_valid && empty_c < 0) empty_c = c;
            if (done) begin done_n++; done_c = c; end
            if (!busy) begin busy_c = c; break; end
        end
        n_vec++;
        if (done_n != 1) begin
            n_err++; $display("FAIL fd_done_width: done high %0d cycles, expected 1", done_n);
        end
        n_vec++;
        if (done_c != empty_c + 1) begin
            n_err++; $display("FAIL fd_done_time: done at %0d, expected %0d", done_c, empty_c + 1);
        end
        n_vec++;
        if (busy_c != done_c + 1) begin
            n_err++; $display("FAIL fd_busy_fall: busy low at %0d, expected %0d", busy_c, done_c + 1);
        end
        n_vec++;
        if (words_written !== 16'd2) begin
            n_err++; $display("FAIL fd_count: got %0d, expected 2", words_written);
        end
        check_empty_q("fd");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd16, 5'd9, 5'd31};
        logic [32:0] e;
        logic [4:0]  op;
        logic        isi;
        logic [4:0]  a, b, c;
        logic [11:0] im;
        int          legal_n = 0;
        imem_ready = 0;
        do_start({$urandom_range(0, 32'h3FFF), 2'b00});
        rand_ready = 1;
        for (int i = 0; i < 16; i++) begin
            op  = ops[$urandom_range(0, 11)];
            isi = 1'($urandom_range(0, 1));
            a   = 5'($urandom_range(0, 31));
            b   = 5'($urandom_range(0, 31));
            c   = 5'($urandom_range(0, 31));
            im  = 12'($urandom_range(0, 4095));
            e   = model(op, isi, a, b, c, im);
            if (e[32]) legal_n++;
            send(op, isi, a, b, c, im, e, "b2b");
        end
        do_flush();
        rand_ready = 0;
        @(posedge clk); #1;
        imem_ready = 1;
        wait_idle("b2b");
        n_vec++;
        if (words_written !== 16'(legal_n)) begin
            n_err++; $display("FAIL b2b_count: got %0d, expected %0d", words_written, legal_n);
        end
        check_empty_q("b2b");
    endtask

    task automatic test_reset_mid();
        imem_ready = 0;
        do_start(32'h600);
        for (int i = 0; i < 4; i++) begin
            send(5'd8, 1'b0, 5'(i), 5'd1, 5'd2, 12'h0, model(5'd8, 1'b0, 5'(i), 5'd1, 5'd2, 12'h0), "rm");
        end
        @(posedge clk); #1;
        imem_ready = 1;
        @(posedge clk); #1;
        imem_ready = 0;
        do_flush();
        @(negedge clk);
        n_vec++;
        if (words_written !== 16'd1 || busy !== 1'b1 || imem_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rm_pre: got count=%0d busy=%b valid=%b, expected 1 1 1", words_written, busy, imem_valid);
        end
        @(posedge clk); #1;
        rst = 1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_vec++;
        if (imem_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rm_flags: got valid=%b busy=%b, expected 0 0", imem_valid, busy);
        end
        n_vec++;
        if (words_written !== '0) begin
            n_err++; $display("FAIL rm_count: got %0d, expected 0", words_written);
        end
        n_vec++;
        if (imem_addr !== '0) begin
            n_err++; $display("FAIL rm_addr: got %h, expected 0", imem_addr);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sub();
        test_srai();
        test_illegal();
        test_backpressure();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
